// File: rtl/adar_spi_scheduler.sv
// adar_spi_scheduler: arbitrates two 24-bit frame requesters onto one ADAR SPI port.
// Optional macro ADAR_SPI_PRIORITY_EN: requester 0 gets strict priority instead of round-robin.
module adar_spi_scheduler #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        req0_valid,
    input  logic [23:0] req0_cmd,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [23:0] req1_cmd,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_src,
    output logic        rsp_read,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic        sclk,
    output logic        csb,
    output logic        sdio_o,
    input  logic        sdo_i
);

    localparam int unsigned MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam int unsigned BIT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [BIT_W-1:0]   bit_idx, nxt_bit;
    logic [23:0]        cmd_q, nxt_cmd;
    logic               src_q, nxt_src;
    logic [7:0]         rx_q, nxt_rx;
    logic               nxt_csb, nxt_sclk, nxt_sdio, nxt_busy;
    logic               nxt_rsp_valid, nxt_rsp_src, nxt_rsp_read;
    logic [7:0]         nxt_rsp_data;
    logic               idle, gnt0, gnt1;

    assign idle = (state == S_IDLE);

`ifdef ADAR_SPI_PRIORITY_EN
    assign gnt0 = idle && req0_valid;
`else
    logic rr_last;

    // Round-robin pointer: remembers the last granted requester (1 after reset so 0 wins first).
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rr_last <= 1'b1;
        end else if (gnt0) begin
            rr_last <= 1'b0;
        end else if (gnt1) begin
            rr_last <= 1'b1;
        end
    end

    assign gnt0 = idle && req0_valid && (!req1_valid || rr_last);
`endif

    assign gnt1       = idle && req1_valid && !gnt0;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // State and datapath registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            cmd_q     <= '0;
            src_q     <= 1'b0;
            rx_q      <= '0;
            csb       <= 1'b1;
            sclk      <= 1'b0;
            sdio_o    <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_src   <= 1'b0;
            rsp_read  <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            bit_idx   <= nxt_bit;
            cmd_q     <= nxt_cmd;
            src_q     <= nxt_src;
            rx_q      <= nxt_rx;
            csb       <= nxt_csb;
            sclk      <= nxt_sclk;
            sdio_o    <= nxt_sdio;
            busy      <= nxt_busy;
            rsp_valid <= nxt_rsp_valid;
            rsp_src   <= nxt_rsp_src;
            rsp_read  <= nxt_rsp_read;
            rsp_data  <= nxt_rsp_data;
        end
    end

    // Frame sequencing: setup, 24 MSB-first bits (change on sclk fall, sample on rise), hold, gap.
    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_bit       = bit_idx;
        nxt_cmd       = cmd_q;
        nxt_src       = src_q;
        nxt_rx        = rx_q;
        nxt_csb       = csb;
        nxt_sclk      = sclk;
        nxt_sdio      = sdio_o;
        nxt_rsp_valid = 1'b0;
        nxt_rsp_src   = rsp_src;
        nxt_rsp_read  = rsp_read;
        nxt_rsp_data  = rsp_data;

        case (state)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    nxt_state = S_SETUP;
                    nxt_cmd   = gnt0 ? req0_cmd : req1_cmd;
                    nxt_src   = gnt1;
                    nxt_rx    = '0;
                    nxt_csb   = 1'b0;
                    nxt_sclk  = 1'b0;
                    nxt_sdio  = nxt_cmd[23];
                    nxt_bit   = BIT_W'(23);
                    nxt_cnt   = CNT_W'(CS_SETUP - 1);
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    nxt_state = S_SHIFT;
                    nxt_cnt   = CNT_W'(CLK_DIV - 1);
                end else begin
                    nxt_cnt = cnt - CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - CNT_W'(1);
                end else if (!sclk) begin
                    nxt_sclk = 1'b1;
                    nxt_cnt  = CNT_W'(CLK_DIV - 1);
                    if (bit_idx <= BIT_W'(7)) begin
                        nxt_rx = {rx_q[6:0], sdo_i};
                    end
                end else begin
                    nxt_sclk = 1'b0;
                    if (bit_idx == '0) begin
                        nxt_state = S_HOLD;
                        nxt_cnt   = CNT_W'(CS_HOLD - 1);
                    end else begin
                        nxt_bit  = bit_idx - BIT_W'(1);
                        nxt_sdio = cmd_q[nxt_bit];
                        nxt_cnt  = CNT_W'(CLK_DIV - 1);
                    end
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    nxt_state     = S_GAP;
                    nxt_csb       = 1'b1;
                    nxt_rsp_valid = 1'b1;
                    nxt_rsp_src   = src_q;
                    nxt_rsp_read  = cmd_q[23];
                    nxt_rsp_data  = cmd_q[23] ? rx_q : 8'h00;
                    nxt_cnt       = CNT_W'(CS_GAP - 1);
                end else begin
                    nxt_cnt = cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    nxt_state = S_IDLE;
                end else begin
                    nxt_cnt = cnt - CNT_W'(1);
                end
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_csb   = 1'b1;
                nxt_sclk  = 1'b0;
            end
        endcase

        nxt_busy = (nxt_state != S_IDLE);
    end

endmodule
